madd_unit: RTL and testbench

EX-stage sequencer for MIPS multiply-accumulate instructions (MADD, MADDU, MSUB, MSUBU). It is the producing end of the HI/LO-temporary and multiply-count loop carried by the EX/MEM pipeline register. It requests a pipeline stall, computes the 64-bit product in one cycle and accumulates it into {HI,LO} in the next. It presents the HI/LO write to the pipeline in the same encoding as the ordinary HI/LO write path.

---
 rtl/madd_unit.sv | 162 ++++++++++++++++
 tb/tb_madd_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/madd_unit.sv
// madd_unit: EX-stage sequencer for MADD/MADDU/MSUB/MSUBU.
// It stalls EX for two cycles. In MUL it forms the 64-bit product of the
// latched operands. In ACC it adds that product to, or subtracts it from,
// the live {HI,LO}, then presents the write.
//
// Build option: define MADD_MSUB_EN to support MSUB/MSUBU.
// Without it, op[1]=1 is treated as illegal and the subtract path is omitted.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; stall_req follows a legal start
// MUL   | product of latched operands registered into hilo_tmp
// ACC   | {hi_in,lo_in} +/- hilo_tmp presented with hilo_wen (held on hold)
`timescale 1ns/1ps

module madd_unit #(
   parameter int REG_DATA_WIDTH    = 32,
   parameter int DOUBLE_DATA_WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [1:0]                   op,
   input  logic [REG_DATA_WIDTH-1:0]    src1,
   input  logic [REG_DATA_WIDTH-1:0]    src2,
   input  logic [REG_DATA_WIDTH-1:0]    hi_in,
   input  logic [REG_DATA_WIDTH-1:0]    lo_in,
   input  logic                         hold,
   input  logic                         flush,
   output logic                         stall_req,
   output logic [DOUBLE_DATA_WIDTH-1:0] hilo_tmp_out,
   output logic [1:0]                   mul_cnt_out,
   output logic [REG_DATA_WIDTH-1:0]    hi_out,
   output logic [REG_DATA_WIDTH-1:0]    lo_out,
   output logic                         hilo_wen
);

   localparam int DW  = REG_DATA_WIDTH;
   localparam int DDW = DOUBLE_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [DW-1:0]    src1_q;
   logic [DW-1:0]    src2_q;
   logic             op_uns_q;
   logic [DDW-1:0]   hilo_tmp_q;
   logic             op_legal;
   logic             launch;
   logic [DDW-1:0]   ext_a;
   logic [DDW-1:0]   ext_b;
   logic [DDW-1:0]   product;
   logic [DDW-1:0]   acc_in;
   logic [DDW-1:0]   acc_res;

`ifdef MADD_MSUB_EN
   logic             op_sub_q;
   assign op_legal = 1'b1;
`else
   assign op_legal = ~op[1];
`endif

   assign launch = (state_q == IDLE) && start && op_legal;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; flush outranks hold and start
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (launch) state_d = MUL;
            MUL:     state_d = ACC;
            ACC:     if (!hold) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Operand latch: captured only on a legal launch, so later EX changes are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src1_q   <= '0;
         src2_q   <= '0;
         op_uns_q <= 1'b0;
`ifdef MADD_MSUB_EN
         op_sub_q <= 1'b0;
`endif
      end else if (launch) begin
         src1_q   <= src1;
         src2_q   <= src2;
         op_uns_q <= op[0];
`ifdef MADD_MSUB_EN
         op_sub_q <= op[1];
`endif
      end
   end

   // Extend to 64 bits, then take a truncated 64x64 multiply.
   // Modulo 2^64 this equals the exact signed or unsigned 32x32 product.
   always_comb begin
      ext_a   = {{DW{~op_uns_q & src1_q[DW-1]}}, src1_q};
      ext_b   = {{DW{~op_uns_q & src2_q[DW-1]}}, src2_q};
      product = ext_a * ext_b;
   end

   // Product register: loaded in MUL, cleared on flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                hilo_tmp_q <= '0;
      else if (flush)            hilo_tmp_q <= '0;
      else if (state_q == MUL)   hilo_tmp_q <= product;
   end

   // Accumulate against the live HI/LO so forwarded values are honoured
   always_comb begin
      acc_in = {hi_in, lo_in};
`ifdef MADD_MSUB_EN
      acc_res = op_sub_q ? (acc_in - hilo_tmp_q) : (acc_in + hilo_tmp_q);
`else
      acc_res = acc_in + hilo_tmp_q;
`endif
   end

   // Outputs: zero unless the state drives them; stall_req is forced low during reset
   always_comb begin
      stall_req    = 1'b0;
      hilo_tmp_out = '0;
      mul_cnt_out  = 2'd0;
      hi_out       = '0;
      lo_out       = '0;
      hilo_wen     = 1'b0;
      case (state_q)
         IDLE: stall_req = launch;
         MUL: begin
            stall_req   = 1'b1;
            mul_cnt_out = 2'd1;
         end
         ACC: begin
            mul_cnt_out  = 2'd2;
            hilo_tmp_out = hilo_tmp_q;
            if (!flush) begin
               hilo_wen         = 1'b1;
               {hi_out, lo_out} = acc_res;
            end
         end
         default: ;
      endcase
      stall_req = stall_req & rst_n;
   end

endmodule

// File: tb/tb_madd_unit.sv
// tb_madd_unit: directed scoreboard bench for madd_unit.
`timescale 1ns/1ps

module tb_madd_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src1 = '0, src2 = '0, hi_in = '0, lo_in = '0;
   logic        stall_req, hilo_wen;
   logic [63:0] hilo_tmp_out;
   logic [1:0]  mul_cnt_out;
   logic [31:0] hi_out, lo_out;

   madd_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src1(src1), .src2(src2), .hi_in(hi_in), .lo_in(lo_in),
      .hold(hold), .flush(flush), .stall_req(stall_req),
      .hilo_tmp_out(hilo_tmp_out), .mul_cnt_out(mul_cnt_out),
      .hi_out(hi_out), .lo_out(lo_out), .hilo_wen(hilo_wen)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] tmp;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle with hilo_wen high consumes one expected entry
   always @(negedge clk) begin
      exp_t e;
      if (hilo_wen === 1'b1) begin
         if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_wen: got hilo_wen=1, expected 0 (no pending op, t=%0t)", $time);
         end else begin
            e = sbq.pop_front();
            chk("acc_hi",  {32'd0, hi_out}, {32'd0, e.hi});
            chk("acc_lo",  {32'd0, lo_out}, {32'd0, e.lo});
            chk("acc_tmp", hilo_tmp_out, e.tmp);
            chk("acc_cnt", {62'd0, mul_cnt_out}, 64'd2);
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one op. The pipeline holds start through MUL and through held ACC
   // cycles, and scrambles the operands after issue. nhold = extra ACC cycles.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         input logic [63:0] etmp, input logic [31:0] ehi,
                         input logic [31:0] elo, input int nhold);
      exp_t e;
      cycle();
      start = 1'b1; op = o; src1 = a; src2 = b; hi_in = h; lo_in = l;
      #1;
      chk("issue_stall", {63'd0, stall_req}, 64'd1);
      chk("issue_cnt",   {62'd0, mul_cnt_out}, 64'd0);
      e.tmp = etmp; e.hi = ehi; e.lo = elo;
      for (int i = 0; i <= nhold; i++) sbq.push_back(e);
      cycle();
      src1 = ~a; src2 = b + 32'd1; op = ~o;
      #1;
      chk("mul_stall", {63'd0, stall_req}, 64'd1);
      chk("mul_cnt",   {62'd0, mul_cnt_out}, 64'd1);
      cycle();
      hold  = (nhold > 0);
      start = (nhold > 0);
      #1;
      chk("acc_stall", {63'd0, stall_req}, 64'd0);
      for (int i = 1; i <= nhold; i++) begin
         cycle();
         hold  = (i < nhold);
         start = (i < nhold);
         #1;
         chk("hold_cnt",   {62'd0, mul_cnt_out}, 64'd2);
         chk("hold_stall", {63'd0, stall_req}, 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_stall", {63'd0, stall_req}, 64'd0);
      chk("rst_cnt",   {62'd0, mul_cnt_out}, 64'd0);
      chk("rst_wen",   {63'd0, hilo_wen}, 64'd0);
      chk("rst_hilo",  {hi_out, lo_out}, 64'd0);
      chk("rst_tmp",   hilo_tmp_out, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // MADDU 0xFFFFFFFF*2 + 1
      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1,
             64'h0000_0001_FFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 0);
      // MADD -3*4 + 20
      run_op(2'b00, 32'hFFFF_FFFD, 32'd4, 32'd0, 32'd20,
             64'hFFFF_FFFF_FFFF_FFF4, 32'h0, 32'h8, 0);
      // MADD -1*-1 with a carry from LO into HI
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF,
             64'h1, 32'h1234_5679, 32'h0, 0);
      // MADDU 0xFFFFFFFF^2 shows the unsigned product
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
             64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      // MADDU wraps modulo 2^64
      run_op(2'b01, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             64'h1, 32'h0, 32'h0, 0);
`ifdef MADD_MSUB_EN
      run_op(2'b10, 32'd5, 32'd6, 32'd0, 32'd10,
             64'h1E, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 0);
      run_op(2'b11, 32'd5, 32'd6, 32'd0, 32'd10,
             64'h1E, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 0);
`endif
      // Hold in ACC for 3 cycles, then issue back to back with no bubble
      run_op(2'b00, 32'd7, 32'd3, 32'd0, 32'd1, 64'd21, 32'd0, 32'd22, 3);
      run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd2, 32'd5,
             64'h1_0000_0000, 32'd3, 32'd5, 0);

      // Flush during MUL
      cycle();
      start = 1'b1; op = 2'b00; src1 = 32'd9; src2 = 32'd9; hi_in = 0; lo_in = 0;
      #1 chk("flush_issue", {63'd0, stall_req}, 64'd1);
      cycle();
      flush = 1'b1; start = 1'b0;
      #1 chk("flush_mulcnt", {62'd0, mul_cnt_out}, 64'd1);
      cycle();
      flush = 1'b0;
      #1;
      chk("flush_cnt",   {62'd0, mul_cnt_out}, 64'd0);
      chk("flush_wen",   {63'd0, hilo_wen}, 64'd0);
      chk("flush_stall", {63'd0, stall_req}, 64'd0);
      repeat (3) cycle();

      // Asynchronous reset in the middle of MUL
      cycle();
      start = 1'b1; op = 2'b01; src1 = 32'd3; src2 = 32'd3;
      cycle();
      #1 rst_n = 1'b0;
      #1;
      chk("amid_stall", {63'd0, stall_req}, 64'd0);
      chk("amid_cnt",   {62'd0, mul_cnt_out}, 64'd0);
      chk("amid_wen",   {63'd0, hilo_wen}, 64'd0);
      chk("amid_tmp",   hilo_tmp_out, 64'd0);
      chk("amid_hilo",  {hi_out, lo_out}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

`ifndef MADD_MSUB_EN
      // Without the subtract ops, MSUB and MSUBU are refused
      cycle();
      start = 1'b1; op = 2'b10; src1 = 32'd5; src2 = 32'd6; hi_in = 0; lo_in = 32'd10;
      #1 chk("ill_stall0", {63'd0, stall_req}, 64'd0);
      cycle();
      #1;
      chk("ill_cnt1",   {62'd0, mul_cnt_out}, 64'd0);
      chk("ill_stall1", {63'd0, stall_req}, 64'd0);
      op = 2'b11;
      #1 chk("ill_stall_u", {63'd0, stall_req}, 64'd0);
      cycle();
      start = 1'b0;
      #1 chk("ill_cnt2", {62'd0, mul_cnt_out}, 64'd0);
`endif
      run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd0, 64'd6, 32'd0, 32'd6, 0);

      repeat (3) cycle();
      chk("queue_drained", sbq.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
